// File: rtl/gnn_pkg.sv
// gnn_pkg: shared widths, types and issue-FSM states for the vertex datapath
`ifndef FV_size
`define FV_size 16
`endif
`ifndef Mult_per_PE
`define Mult_per_PE 4
`endif
`ifndef Max_Node_id
`define Max_Node_id 256
`endif
package gnn_pkg;
  localparam int LANES = `Mult_per_PE;
  localparam int NW = $clog2(`Max_Node_id);
  typedef logic [`FV_size-1:0] fv_t;
  typedef logic [NW-1:0] node_id_t;
  typedef enum logic {IDLE, ISSUE} issue_state_t;
endpackage

// File: rtl/vertex_fv_fifo.sv
// vertex_fv_fifo: small vector queue; ready only while not full, no full-bypass
module vertex_fv_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         head_valid,
  output logic [W-1:0] head_data,
  input  logic         pop
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] cnt_t;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  cnt_t count;
  logic push, do_pop;
  assign in_ready = count < cnt_t'(DEPTH);
  assign head_valid = count != '0;
  assign head_data = mem[rd_ptr];
  assign push = in_valid && in_ready;
  assign do_pop = pop && head_valid;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + cnt_t'(push) - cnt_t'(do_pop);
    end
  // payload storage needs no reset; count guards every read
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
endmodule

// File: rtl/vertex_fv_issue.sv
// vertex_fv_issue: streams queued feature vectors to the PE as 4-lane chunks with matching weights
module vertex_fv_issue
  import gnn_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CHUNKS = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wt_wr_en,
  input  logic [$clog2(CHUNKS*LANES)-1:0]     wt_wr_addr,
  input  logic [`FV_size-1:0]                 wt_wr_data,
  input  logic                                fv_valid,
  output logic                                fv_ready,
  input  logic [NW-1:0]                       fv_node_id,
  input  logic [CHUNKS*LANES*`FV_size-1:0]    fv_data,
  input  logic                                issue_stall,
  output logic                                issue_valid,
  output logic                                issue_last,
  output logic [`FV_size-1:0]                 FV_RS_0,
  output logic [`FV_size-1:0]                 FV_RS_1,
  output logic [`FV_size-1:0]                 FV_RS_2,
  output logic [`FV_size-1:0]                 FV_RS_3,
  output logic [`FV_size-1:0]                 Weight_data_in_0,
  output logic [`FV_size-1:0]                 Weight_data_in_1,
  output logic [`FV_size-1:0]                 Weight_data_in_2,
  output logic [`FV_size-1:0]                 Weight_data_in_3,
  output logic [NW-1:0]                       Node_id
);
  localparam int WN = CHUNKS*LANES;
  localparam int WA = $clog2(WN);
  localparam int BW = $clog2(WN*`FV_size);
  localparam int CW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
  localparam int PW = NW + WN*`FV_size;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST_C = cnt_t'(CHUNKS-1);
  logic [PW-1:0] head_data;
  logic [WN*`FV_size-1:0] head_vec;
  node_id_t head_node, node_d;
  logic head_valid, pop, start, adv, stop, load, valid_d, last_d;
  issue_state_t state_q, state_d;
  cnt_t chunk_cnt, cnt_d, sel;
  fv_t wt_q [WN];
  fv_t fv_lane_q [LANES];
  fv_t wt_lane_q [LANES];
  fv_t fv_lane_d [LANES];
  fv_t wt_lane_d [LANES];
  vertex_fv_fifo #(.DEPTH(DEPTH), .W(PW)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (fv_valid),
    .in_ready   (fv_ready),
    .in_data    ({fv_node_id, fv_data}),
    .head_valid (head_valid),
    .head_data  (head_data),
    .pop        (pop)
  );
  assign {head_node, head_vec} = head_data;
  assign FV_RS_0 = fv_lane_q[0];
  assign FV_RS_1 = fv_lane_q[1];
  assign FV_RS_2 = fv_lane_q[2];
  assign FV_RS_3 = fv_lane_q[3];
  assign Weight_data_in_0 = wt_lane_q[0];
  assign Weight_data_in_1 = wt_lane_q[1];
  assign Weight_data_in_2 = wt_lane_q[2];
  assign Weight_data_in_3 = wt_lane_q[3];
  // weight register file; a chunk loaded on a write edge still sees the old value
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < WN; i++) wt_q[i] <= '0;
    else if (wt_wr_en) wt_q[wt_wr_addr] <= wt_wr_data;
  // next chunk selection: start a new head (from IDLE or right after a last chunk), step, or drain to IDLE
  always_comb begin
    start = !issue_stall && head_valid && (state_q == IDLE || issue_last);
    adv = !issue_stall && state_q == ISSUE && !issue_last;
    stop = !issue_stall && state_q == ISSUE && issue_last && !head_valid;
    load = start || adv;
    sel = start ? '0 : chunk_cnt + cnt_t'(1);
    pop = load && sel == LAST_C;
    state_d = load ? ISSUE : stop ? IDLE : state_q;
    cnt_d = load ? sel : stop ? '0 : chunk_cnt;
    valid_d = load ? 1'b1 : stop ? 1'b0 : issue_valid;
    last_d = load ? sel == LAST_C : stop ? 1'b0 : issue_last;
    node_d = load ? head_node : stop ? '0 : Node_id;
    for (int j = 0; j < LANES; j++) begin
      fv_lane_d[j] = load ? head_vec[BW'((int'(sel)*LANES + j)*`FV_size) +: `FV_size] : stop ? '0 : fv_lane_q[j];
      wt_lane_d[j] = load ? wt_q[WA'(int'(sel)*LANES + j)] : stop ? '0 : wt_lane_q[j];
    end
  end
  // registered issue outputs and FSM state
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      chunk_cnt <= '0;
      issue_valid <= 1'b0;
      issue_last <= 1'b0;
      Node_id <= '0;
      for (int j = 0; j < LANES; j++) begin
        fv_lane_q[j] <= '0;
        wt_lane_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      chunk_cnt <= cnt_d;
      issue_valid <= valid_d;
      issue_last <= last_d;
      Node_id <= node_d;
      for (int j = 0; j < LANES; j++) begin
        fv_lane_q[j] <= fv_lane_d[j];
        wt_lane_q[j] <= wt_lane_d[j];
      end
    end
endmodule

// File: tb/tb_vertex_fv_issue.sv
// tb_vertex_fv_issue: directed vector-table and sequence checks for the operand issue stage
module tb_vertex_fv_issue;
  import gnn_pkg::*;
  logic clk = 0, reset = 0, wt_wr_en = 0, fv_valid = 0, issue_stall = 0;
  logic [3:0] wt_wr_addr = 0;
  fv_t wt_wr_data = 0;
  node_id_t fv_node_id = 0;
  logic [16*$bits(fv_t)-1:0] fv_data = 0;
  logic fv_ready, issue_valid, issue_last;
  fv_t f0, f1, f2, f3, w0, w1, w2, w3;
  node_id_t node;
  int checks = 0, errors = 0;
  typedef struct {
    logic v;
    logic l;
    int   n;
    int   fv0;
    int   wt0;
    logic r;
  } row_t;
  row_t tbl [14];

  always #5 clk = ~clk;

  vertex_fv_issue dut (
    .clk(clk), .reset(reset), .wt_wr_en(wt_wr_en), .wt_wr_addr(wt_wr_addr), .wt_wr_data(wt_wr_data),
    .fv_valid(fv_valid), .fv_ready(fv_ready), .fv_node_id(fv_node_id), .fv_data(fv_data),
    .issue_stall(issue_stall), .issue_valid(issue_valid), .issue_last(issue_last),
    .FV_RS_0(f0), .FV_RS_1(f1), .FV_RS_2(f2), .FV_RS_3(f3),
    .Weight_data_in_0(w0), .Weight_data_in_1(w1), .Weight_data_in_2(w2), .Weight_data_in_3(w3),
    .Node_id(node)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk(input int base);
    logic [255:0] v;
    for (int e = 0; e < 16; e++) v[e*16 +: 16] = 16'(base + e);
    return v;
  endfunction

  function automatic row_t rw(input logic v, input logic l, input int n, input int c, input logic r);
    row_t x;
    x.v = v;
    x.l = l;
    x.n = v ? n : 0;
    x.fv0 = v ? n*16 + 256 + c*4 : 0;
    x.wt0 = v ? c*4 + 1 : 0;
    x.r = r;
    return x;
  endfunction

  task automatic send(input int n, input int base);
    fv_valid = 1;
    fv_node_id = 8'(n);
    fv_data = mk(base);
  endtask

  initial begin
    int p, nv;
    logic acc;
    tbl[0] = rw(0, 0, 0, 0, 1);
    tbl[1] = rw(1, 0, 1, 0, 0);
    tbl[2] = rw(1, 0, 1, 1, 0);
    tbl[3] = rw(1, 0, 1, 2, 0);
    tbl[4] = rw(1, 1, 1, 3, 1);
    tbl[5] = rw(1, 0, 2, 0, 0);
    tbl[6] = rw(1, 0, 2, 1, 0);
    tbl[7] = rw(1, 0, 2, 2, 0);
    tbl[8] = rw(1, 1, 2, 3, 1);
    tbl[9] = rw(1, 0, 3, 0, 1);
    tbl[10] = rw(1, 0, 3, 1, 1);
    tbl[11] = rw(1, 0, 3, 2, 1);
    tbl[12] = rw(1, 1, 3, 3, 1);
    tbl[13] = rw(0, 0, 0, 0, 1);
    step;
    step;
    chk("rst_valid", issue_valid, 0);
    chk("rst_last", issue_last, 0);
    chk("rst_fv0", f0, 0);
    chk("rst_wt3", w3, 0);
    chk("rst_node", node, 0);
    chk("rst_ready", fv_ready, 1);
    reset = 1;
    step;
    for (int e = 0; e < 16; e++) begin
      wt_wr_en = 1;
      wt_wr_addr = 4'(e);
      wt_wr_data = 16'(e + 1);
      step;
    end
    wt_wr_en = 0;
    // chunk mapping
    send(5, 16);
    step;
    fv_valid = 0;
    chk("map_valid_early", issue_valid, 0);
    step;
    chk("map_c0_valid", issue_valid, 1);
    chk("map_c0_last", issue_last, 0);
    chk("map_c0_node", node, 5);
    chk("map_c0_fv", {f3, f2, f1, f0}, {16'd19, 16'd18, 16'd17, 16'd16});
    chk("map_c0_wt", {w3, w2, w1, w0}, {16'd4, 16'd3, 16'd2, 16'd1});
    step;
    step;
    step;
    chk("map_c3_last", issue_last, 1);
    chk("map_c3_fv", {f3, f2, f1, f0}, {16'd31, 16'd30, 16'd29, 16'd28});
    chk("map_c3_wt", {w3, w2, w1, w0}, {16'd16, 16'd15, 16'd14, 16'd13});
    step;
    chk("map_end_valid", issue_valid, 0);
    chk("map_end_last", issue_last, 0);
    chk("map_end_fv", f0, 0);
    chk("map_end_node", node, 0);
    // back-to-back table
    p = 0;
    send(1, 272);
    for (int k = 0; k < 14; k++) begin
      acc = fv_valid && fv_ready;
      step;
      if (acc) p++;
      fv_valid = p < 3;
      fv_node_id = 8'(p + 1);
      fv_data = mk((p + 1)*16 + 256);
      chk($sformatf("b2b[%0d].valid", k), issue_valid, tbl[k].v);
      chk($sformatf("b2b[%0d].last", k), issue_last, tbl[k].l);
      chk($sformatf("b2b[%0d].node", k), node, tbl[k].n);
      chk($sformatf("b2b[%0d].fv0", k), f0, tbl[k].fv0);
      chk($sformatf("b2b[%0d].wt0", k), w0, tbl[k].wt0);
      chk($sformatf("b2b[%0d].ready", k), fv_ready, tbl[k].r);
    end
    fv_valid = 0;
    // stall while chunk 1 is showing
    send(4, 320);
    step;
    fv_valid = 0;
    step;
    step;
    chk("stall_c1", f0, 324);
    nv = 2;
    issue_stall = 1;
    for (int k = 0; k < 3; k++) begin
      step;
      chk("stall_hold_fv", f0, 324);
      chk("stall_hold_valid", issue_valid, 1);
      if (issue_valid) nv++;
    end
    issue_stall = 0;
    step;
    chk("stall_resume_c2", f0, 328);
    if (issue_valid) nv++;
    for (int k = 0; k < 4; k++) begin
      step;
      if (issue_valid) nv++;
    end
    chk("stall_valid_cycles", nv, 7);
    // weight write on the edge that loads chunk 1
    send(6, 352);
    step;
    send(8, 384);
    step;
    fv_valid = 0;
    wt_wr_en = 1;
    wt_wr_addr = 5;
    wt_wr_data = 99;
    step;
    wt_wr_en = 0;
    chk("wwr_old_w5", w1, 6);
    chk("wwr_old_fv", f1, 357);
    step;
    step;
    step;
    step;
    chk("wwr_new_node", node, 8);
    chk("wwr_new_w5", w1, 99);
    step;
    step;
    step;
    chk("wwr_drain", issue_valid, 0);
    // asynchronous reset mid-issue with one vector queued
    send(7, 400);
    step;
    send(9, 416);
    step;
    fv_valid = 0;
    step;
    step;
    chk("rmid_c2", f0, 408);
    reset = 0;
    #2;
    chk("rmid_valid", issue_valid, 0);
    chk("rmid_last", issue_last, 0);
    chk("rmid_fv", f0, 0);
    chk("rmid_wt", w0, 0);
    chk("rmid_node", node, 0);
    chk("rmid_ready", fv_ready, 1);
    @(posedge clk);
    #3;
    reset = 1;
    nv = 0;
    for (int k = 0; k < 6; k++) begin
      step;
      if (issue_valid) nv++;
    end
    chk("rmid_no_stale", nv, 0);
    send(10, 432);
    step;
    fv_valid = 0;
    step;
    chk("rmid_post_fv", f0, 432);
    chk("rmid_wt_cleared", w0, 0);
    for (int k = 0; k < 4; k++) step;
    // full FIFO with fv_valid held
    send(11, 448);
    step;
    send(12, 464);
    step;
    chk("full_e2_ready", fv_ready, 0);
    send(13, 480);
    step;
    chk("full_e3_ready", fv_ready, 0);
    step;
    chk("full_e4_ready", fv_ready, 0);
    step;
    chk("full_pop_last", issue_last, 1);
    chk("full_pop_ready", fv_ready, 1);
    step;
    fv_valid = 0;
    chk("full_e6_ready", fv_ready, 0);
    chk("full_e6_node", node, 12);
    for (int k = 0; k < 12; k++) step;
    chk("full_drain", issue_valid, 0);
    chk("full_drain_ready", fv_ready, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
